// File: rtl/stopwatch_ctrl_pkg.sv
// Shared encodings and widths for the stopwatch control sequencer.
// Also holds the single-pulse priority resolver used by the FSM.
package stopwatch_ctrl_pkg;

  localparam int unsigned BCD_W   = 16;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned CNT_W   = 4;

  localparam logic [STATE_W-1:0] IDLE_S     = 3'd0;
  localparam logic [STATE_W-1:0] RUN_S      = 3'd1;
  localparam logic [STATE_W-1:0] EDIT_H_S   = 3'd2;
  localparam logic [STATE_W-1:0] EDIT_TS_S  = 3'd3;
  localparam logic [STATE_W-1:0] EDIT_S_S   = 3'd4;
  localparam logic [STATE_W-1:0] EDIT_T_S   = 3'd5;
  localparam logic [STATE_W-1:0] LAP_VIEW_S = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = IDLE_S,
    ST_RUN      = RUN_S,
    ST_EDIT_H   = EDIT_H_S,
    ST_EDIT_TS  = EDIT_TS_S,
    ST_EDIT_S   = EDIT_S_S,
    ST_EDIT_T   = EDIT_T_S,
    ST_LAP_VIEW = LAP_VIEW_S
  } state_e;

  localparam logic [SEL_W-1:0] SEL_NONE    = 4'b0000;
  localparam logic [SEL_W-1:0] SEL_EDIT_H  = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_EDIT_TS = 4'b0010;
  localparam logic [SEL_W-1:0] SEL_EDIT_S  = 4'b0100;
  localparam logic [SEL_W-1:0] SEL_EDIT_T  = 4'b1000;

  typedef struct packed {
    logic start;
    logic set;
    logic lap;
    logic change;
  } pulse_t;

  // At most one pulse survives: start > set > lap > change.
  function automatic pulse_t prio_pulse(input logic st, input logic se,
                                        input logic la, input logic ch);
    pulse_t p;
    p.start  = st;
    p.set    = se & ~st;
    p.lap    = la & ~st & ~se;
    p.change = ch & ~st & ~se & ~la;
    return p;
  endfunction

endpackage

// File: rtl/stopwatch_lap_buffer.sv
// Append-only lap snapshot register file with combinational read port.
// Captures beyond DEPTH are dropped; flush empties it without touching data.
module stopwatch_lap_buffer
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                  clk100_i,
  input  logic                                  rstn_i,
  input  logic                                  i_wr_en,
  input  logic [BCD_W-1:0]                      i_wr_data,
  input  logic                                  i_flush,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] i_rd_idx,
  output logic [BCD_W-1:0]                      o_rd_data,
  output logic [CNT_W-1:0]                      o_count,
  output logic                                  o_full
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BCD_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic [IDX_W-1:0] w_wr_ptr;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_wr_ptr = IDX_W'(r_count);

  // Entry storage: the append pointer is simply the current fill count.
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en && !w_full && !i_flush) begin
      r_mem[w_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else if (i_wr_en && !w_full) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];
  assign o_count   = r_count;
  assign o_full    = w_full;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: turns debounced button pulses into run/clear,
// digit-edit increments and lap capture/viewing for the BCD counter chain.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned LAP_DEPTH = 4
) (
  input  logic             clk100_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic             set_i,
  input  logic             change_i,
  input  logic             lap_i,
  input  logic [BCD_W-1:0] time_i,
  output logic             run_o,
  output logic             clear_o,
  output logic [SEL_W-1:0] edit_sel_o,
  output logic             inc_o,
  output logic [BCD_W-1:0] disp_o,
  output logic [CNT_W-1:0] lap_cnt_o,
  output logic             lap_view_o
);

  localparam int unsigned IDX_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

  state_e           r_state;
  logic             r_run;
  logic             r_clear;
  logic [SEL_W-1:0] r_edit_sel;
  logic             r_inc;
  logic             r_lap_view;
  logic [IDX_W-1:0] r_rd_idx;

  pulse_t           w_p;
  logic             w_wr_en;
  logic             w_flush;
  logic             w_full;
  logic [CNT_W-1:0] w_count;
  logic [BCD_W-1:0] w_rd_data;
  logic [IDX_W-1:0] w_rd_next;

  assign w_p = prio_pulse(start_i, set_i, lap_i, change_i);

  assign w_wr_en = (r_state == ST_RUN) && w_p.lap && !w_full;
  assign w_flush = (r_state == ST_LAP_VIEW) && w_p.lap;

  // Read index wraps at the number of stored laps, not at LAP_DEPTH.
  assign w_rd_next = (r_rd_idx == IDX_W'(w_count - CNT_W'(1))) ?
                     '0 : r_rd_idx + IDX_W'(1);

  stopwatch_lap_buffer #(
    .DEPTH (LAP_DEPTH)
  ) u_lap_buffer (
    .clk100_i  (clk100_i),
    .rstn_i    (rstn_i),
    .i_wr_en   (w_wr_en),
    .i_wr_data (time_i),
    .i_flush   (w_flush),
    .i_rd_idx  (r_rd_idx),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_full    (w_full)
  );

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= ST_IDLE;
      r_run      <= 1'b0;
      r_clear    <= 1'b0;
      r_edit_sel <= SEL_NONE;
      r_inc      <= 1'b0;
      r_lap_view <= 1'b0;
      r_rd_idx   <= '0;
    end else begin
      r_clear <= 1'b0;
      r_inc   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_p.start) begin
            r_state <= ST_RUN;
            r_run   <= 1'b1;
          end else if (w_p.set) begin
            r_state    <= ST_EDIT_H;
            r_edit_sel <= SEL_EDIT_H;
          end else if (w_p.lap) begin
            if (w_count == '0) begin
              r_clear <= 1'b1;
            end else begin
              r_state    <= ST_LAP_VIEW;
              r_lap_view <= 1'b1;
              r_rd_idx   <= '0;
            end
          end
        end
        ST_RUN: begin
          if (w_p.start) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
          end
        end
        ST_EDIT_H: begin
          if (w_p.set) begin
            r_state    <= ST_EDIT_TS;
            r_edit_sel <= SEL_EDIT_TS;
          end else if (w_p.change) begin
            r_inc <= 1'b1;
          end
        end
        ST_EDIT_TS: begin
          if (w_p.set) begin
            r_state    <= ST_EDIT_S;
            r_edit_sel <= SEL_EDIT_S;
          end else if (w_p.change) begin
            r_inc <= 1'b1;
          end
        end
        ST_EDIT_S: begin
          if (w_p.set) begin
            r_state    <= ST_EDIT_T;
            r_edit_sel <= SEL_EDIT_T;
          end else if (w_p.change) begin
            r_inc <= 1'b1;
          end
        end
        ST_EDIT_T: begin
          if (w_p.set) begin
            r_state    <= ST_IDLE;
            r_edit_sel <= SEL_NONE;
          end else if (w_p.change) begin
            r_inc <= 1'b1;
          end
        end
        ST_LAP_VIEW: begin
          // Both exits return to IDLE; lap additionally flushes the buffer.
          if (w_p.start || w_p.lap) begin
            r_state    <= ST_IDLE;
            r_lap_view <= 1'b0;
          end else if (w_p.change) begin
            r_rd_idx <= w_rd_next;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_run      <= 1'b0;
          r_edit_sel <= SEL_NONE;
          r_lap_view <= 1'b0;
          r_rd_idx   <= '0;
        end
      endcase
    end
  end

  assign run_o      = r_run;
  assign clear_o    = r_clear;
  assign edit_sel_o = r_edit_sel;
  assign inc_o      = r_inc;
  assign lap_view_o = r_lap_view;
  assign lap_cnt_o  = w_count;
  assign disp_o     = (r_state == ST_LAP_VIEW) ? w_rd_data : time_i;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed vector table, corner
// sequences and randomized pulses against a mode/queue reference model.
module tb_stopwatch_ctrl;

  localparam int DEPTH = 4;

  logic        clk100_i;
  logic        rstn_i;
  logic        start_i, set_i, change_i, lap_i;
  logic [15:0] time_i;
  logic        run_o, clear_o, inc_o, lap_view_o;
  logic [3:0]  edit_sel_o, lap_cnt_o;
  logic [15:0] disp_o;

  int n_checks = 0;
  int n_errors = 0;

  stopwatch_ctrl #(.LAP_DEPTH(DEPTH)) dut (
    .clk100_i   (clk100_i),
    .rstn_i     (rstn_i),
    .start_i    (start_i),
    .set_i      (set_i),
    .change_i   (change_i),
    .lap_i      (lap_i),
    .time_i     (time_i),
    .run_o      (run_o),
    .clear_o    (clear_o),
    .edit_sel_o (edit_sel_o),
    .inc_o      (inc_o),
    .disp_o     (disp_o),
    .lap_cnt_o  (lap_cnt_o),
    .lap_view_o (lap_view_o)
  );

  initial clk100_i = 1'b0;
  always #5 clk100_i = ~clk100_i;

  // Reference model: mode 0 idle, 1 run, 2..5 editing digit (mode-2), 6 lap view
  int          m_mode;
  logic [15:0] m_q[$];
  int          m_vidx;
  logic        m_clr, m_inc;

  function automatic void model_reset();
    m_mode = 0; m_q.delete(); m_vidx = 0; m_clr = 1'b0; m_inc = 1'b0;
  endfunction

  function automatic void model_step(input logic st, input logic se,
                                     input logic la, input logic ch,
                                     input logic [15:0] t);
    m_clr = 1'b0; m_inc = 1'b0;
    if (st) begin
      if (m_mode == 1 || m_mode == 6) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
    end else if (se) begin
      if (m_mode == 0) m_mode = 2;
      else if (m_mode >= 2 && m_mode <= 5) m_mode = (m_mode == 5) ? 0 : m_mode + 1;
    end else if (la) begin
      if (m_mode == 0) begin
        if (m_q.size() == 0) m_clr = 1'b1;
        else begin m_mode = 6; m_vidx = 0; end
      end else if (m_mode == 1) begin
        if (m_q.size() < DEPTH) m_q.push_back(t);
      end else if (m_mode == 6) begin
        m_q.delete(); m_mode = 0;
      end
    end else if (ch) begin
      if (m_mode >= 2 && m_mode <= 5) m_inc = 1'b1;
      else if (m_mode == 6) m_vidx = (m_vidx + 1) % m_q.size();
    end
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic st, input logic se, input logic la,
                       input logic ch, input logic [15:0] t);
    @(negedge clk100_i);
    start_i = st; set_i = se; lap_i = la; change_i = ch; time_i = t;
    @(posedge clk100_i);
    model_step(st, se, la, ch, t);
    #1;
  endtask

  task automatic check_model(input int cyc);
    logic [3:0]  e_sel;
    logic [15:0] e_disp;
    e_sel  = (m_mode >= 2 && m_mode <= 5) ? 4'(1 << (m_mode - 2)) : 4'd0;
    e_disp = (m_mode == 6) ? m_q[m_vidx] : time_i;
    chk($sformatf("rnd%0d run", cyc),   16'(run_o),      16'(m_mode == 1));
    chk($sformatf("rnd%0d clear", cyc), 16'(clear_o),    16'(m_clr));
    chk($sformatf("rnd%0d inc", cyc),   16'(inc_o),      16'(m_inc));
    chk($sformatf("rnd%0d sel", cyc),   16'(edit_sel_o), 16'(e_sel));
    chk($sformatf("rnd%0d cnt", cyc),   16'(lap_cnt_o),  16'(m_q.size()));
    chk($sformatf("rnd%0d view", cyc),  16'(lap_view_o), 16'(m_mode == 6));
    chk($sformatf("rnd%0d disp", cyc),  disp_o,          e_disp);
  endtask

  typedef struct {
    logic        st, se, la, ch;
    logic [15:0] tm;
    logic        run, clr, inc, view;
    logic [3:0]  sel, cnt;
    logic [15:0] disp;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic se, input logic la,
                              input logic ch, input logic [15:0] tm,
                              input logic run, input logic clr, input logic inc,
                              input logic [3:0] sel, input logic [3:0] cnt,
                              input logic view, input logic [15:0] disp);
    vec_t v;
    v.st = st; v.se = se; v.la = la; v.ch = ch; v.tm = tm;
    v.run = run; v.clr = clr; v.inc = inc; v.sel = sel; v.cnt = cnt;
    v.view = view; v.disp = disp;
    return v;
  endfunction

  vec_t tbl[$];
  logic [15:0] sat_t[5];

  initial begin
    start_i = 0; set_i = 0; lap_i = 0; change_i = 0; time_i = 16'hABCD;
    rstn_i = 1'b0;
    model_reset();
    #12;
    chk("rst run",  16'(run_o),      16'h0);
    chk("rst clear",16'(clear_o),    16'h0);
    chk("rst inc",  16'(inc_o),      16'h0);
    chk("rst sel",  16'(edit_sel_o), 16'h0);
    chk("rst cnt",  16'(lap_cnt_o),  16'h0);
    chk("rst view", 16'(lap_view_o), 16'h0);
    chk("rst disp", disp_o,          16'hABCD);
    @(negedge clk100_i);
    rstn_i = 1'b1;

    // Start, ten running cycles, stop
    apply(1, 0, 0, 0, 16'h0000);
    chk("ss run1", 16'(run_o), 16'h1);
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 0, 0, 16'h0000);
      chk($sformatf("ss hold%0d run", i), 16'(run_o), 16'h1);
      chk($sformatf("ss hold%0d clear", i), 16'(clear_o), 16'h0);
    end
    apply(1, 0, 0, 0, 16'h0000);
    chk("ss run0", 16'(run_o), 16'h0);
    chk("ss clear", 16'(clear_o), 16'h0);

    //           st se la ch time      run clr inc sel    cnt view disp
    tbl.push_back(mk(1,0,0,0,16'h1111, 1,0,0,4'h0,4'd0,0,16'h1111));
    tbl.push_back(mk(0,0,1,0,16'h1234, 1,0,0,4'h0,4'd1,0,16'h1234));
    tbl.push_back(mk(0,0,1,0,16'h2345, 1,0,0,4'h0,4'd2,0,16'h2345));
    tbl.push_back(mk(1,0,0,0,16'h0500, 0,0,0,4'h0,4'd2,0,16'h0500));
    tbl.push_back(mk(0,0,1,0,16'h0600, 0,0,0,4'h0,4'd2,1,16'h1234));
    tbl.push_back(mk(0,0,0,1,16'h0700, 0,0,0,4'h0,4'd2,1,16'h2345));
    tbl.push_back(mk(0,0,0,1,16'h0700, 0,0,0,4'h0,4'd2,1,16'h1234));
    tbl.push_back(mk(0,1,0,0,16'h0700, 0,0,0,4'h0,4'd2,1,16'h1234));
    tbl.push_back(mk(1,0,0,0,16'h0800, 0,0,0,4'h0,4'd2,0,16'h0800));
    tbl.push_back(mk(0,0,1,0,16'h0800, 0,0,0,4'h0,4'd2,1,16'h1234));
    tbl.push_back(mk(0,0,1,0,16'h0900, 0,0,0,4'h0,4'd0,0,16'h0900));
    tbl.push_back(mk(0,0,1,0,16'h0900, 0,1,0,4'h0,4'd0,0,16'h0900));
    tbl.push_back(mk(0,0,0,0,16'h0900, 0,0,0,4'h0,4'd0,0,16'h0900));
    tbl.push_back(mk(0,1,0,0,16'h0900, 0,0,0,4'h1,4'd0,0,16'h0900));
    tbl.push_back(mk(0,0,0,1,16'h0900, 0,0,1,4'h1,4'd0,0,16'h0900));
    tbl.push_back(mk(0,0,0,1,16'h0900, 0,0,1,4'h1,4'd0,0,16'h0900));
    tbl.push_back(mk(0,0,0,0,16'h0900, 0,0,0,4'h1,4'd0,0,16'h0900));
    tbl.push_back(mk(0,0,0,1,16'h0900, 0,0,1,4'h1,4'd0,0,16'h0900));
    tbl.push_back(mk(0,1,0,0,16'h0900, 0,0,0,4'h2,4'd0,0,16'h0900));
    tbl.push_back(mk(0,1,0,1,16'h0900, 0,0,0,4'h4,4'd0,0,16'h0900));
    tbl.push_back(mk(1,0,1,0,16'h0900, 0,0,0,4'h4,4'd0,0,16'h0900));
    tbl.push_back(mk(0,1,0,0,16'h0900, 0,0,0,4'h8,4'd0,0,16'h0900));
    tbl.push_back(mk(0,1,0,0,16'h0900, 0,0,0,4'h0,4'd0,0,16'h0900));
    tbl.push_back(mk(1,1,0,0,16'h0900, 1,0,0,4'h0,4'd0,0,16'h0900));
    tbl.push_back(mk(1,0,0,0,16'h0900, 0,0,0,4'h0,4'd0,0,16'h0900));

    foreach (tbl[i]) begin
      apply(tbl[i].st, tbl[i].se, tbl[i].la, tbl[i].ch, tbl[i].tm);
      chk($sformatf("vec%0d run", i),  16'(run_o),      16'(tbl[i].run));
      chk($sformatf("vec%0d clear", i),16'(clear_o),    16'(tbl[i].clr));
      chk($sformatf("vec%0d inc", i),  16'(inc_o),      16'(tbl[i].inc));
      chk($sformatf("vec%0d sel", i),  16'(edit_sel_o), 16'(tbl[i].sel));
      chk($sformatf("vec%0d cnt", i),  16'(lap_cnt_o),  16'(tbl[i].cnt));
      chk($sformatf("vec%0d view", i), 16'(lap_view_o), 16'(tbl[i].view));
      chk($sformatf("vec%0d disp", i), disp_o,          tbl[i].disp);
    end

    // Five captures into a four-entry buffer; the fifth must be dropped
    for (int k = 0; k < 5; k++) sat_t[k] = 16'h0011 * 16'(k + 1);
    apply(1, 0, 0, 0, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      apply(0, 0, 1, 0, sat_t[k]);
      chk($sformatf("sat cap%0d cnt", k), 16'(lap_cnt_o), 16'((k < DEPTH) ? k + 1 : DEPTH));
    end
    apply(1, 0, 0, 0, 16'h0000);
    apply(0, 0, 1, 0, 16'h0000);
    chk("sat view0", disp_o, sat_t[0]);
    for (int k = 1; k <= DEPTH; k++) begin
      apply(0, 0, 0, 1, 16'h0000);
      chk($sformatf("sat view%0d", k), disp_o, sat_t[k % DEPTH]);
    end
    apply(0, 0, 1, 0, 16'h4321);
    chk("sat flush cnt", 16'(lap_cnt_o), 16'h0);
    chk("sat flush disp", disp_o, 16'h4321);

    // Reset asserted while viewing three stored laps
    apply(1, 0, 0, 0, 16'h0000);
    for (int k = 0; k < 3; k++) apply(0, 0, 1, 0, 16'h0900 + 16'(k));
    apply(1, 0, 0, 0, 16'h0000);
    apply(0, 0, 1, 0, 16'h5555);
    chk("mid view", 16'(lap_view_o), 16'h1);
    chk("mid cnt", 16'(lap_cnt_o), 16'h3);
    #2;
    rstn_i = 1'b0;
    #1;
    model_reset();
    chk("mid rst view", 16'(lap_view_o), 16'h0);
    chk("mid rst cnt",  16'(lap_cnt_o),  16'h0);
    chk("mid rst run",  16'(run_o),      16'h0);
    chk("mid rst disp", disp_o,          16'h5555);
    @(negedge clk100_i);
    rstn_i = 1'b1;
    apply(0, 0, 1, 0, 16'h0000);
    chk("mid post clear", 16'(clear_o), 16'h1);
    chk("mid post view",  16'(lap_view_o), 16'h0);

    // Randomized pulses against the reference model
    for (int c = 0; c < 3000; c++) begin
      apply(($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            16'($urandom));
      check_model(c);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Central control sequencer for the stopwatch datapath: converts debounced single-cycle button pulses into counter-chain run enable, clear, per-digit edit increments and a lap-time snapshot buffer. It sits between the key debouncers and the four BCD digit counters. It drives the 16-bit value shown on the 7-segment decoders: either the live time or a stored lap.

## Interface
- LAP_DEPTH, 4: number of lap snapshots stored; a power of two, range 2..8.
- clk100_i  in  1  system clock, 100 MHz.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  start/stop pulse, one cycle, debounced.
- set_i  in  1  edit-mode/next-digit pulse, one cycle.
- change_i  in  1  increment / next-lap pulse, one cycle.
- lap_i  in  1  lap capture / lap view / clear pulse, one cycle.
- time_i  in  16  live BCD time {ten_sec, sec, tenths, hundredths}, 4 bits each.
- run_o  out  1  counter-chain enable.
- clear_o  out  1  one-cycle synchronous clear of all digit counters.
- edit_sel_o  out  4  one-hot digit under edit; bit0 = hundredths, bit3 = ten seconds; 0 when not editing.
- inc_o  out  1  one-cycle increment of the digit selected by edit_sel_o.
- disp_o  out  16  BCD value to display.
- lap_cnt_o  out  4  number of stored laps, 0..LAP_DEPTH.
- lap_view_o  out  1  high while a stored lap is displayed.

## Operation
- States: IDLE, RUN, EDIT_H, EDIT_TS, EDIT_S, EDIT_T, LAP_VIEW.
- Only one pulse is honoured per cycle. Priority is start_i > set_i > lap_i > change_i; lower-priority pulses in the same cycle are dropped.
- IDLE:
  - start_i -> RUN.
  - set_i -> EDIT_H.
  - lap_i with lap_cnt_o == 0 -> clear_o pulse, stay in IDLE.
  - lap_i with lap_cnt_o > 0 -> LAP_VIEW, with read index 0.
  - change_i is ignored.
- RUN:
  - start_i -> IDLE.
  - lap_i writes time_i into the next free entry and increments lap_cnt_o. If the buffer is full, the capture is dropped and nothing changes.
  - set_i and change_i are ignored.
- EDIT_H -> EDIT_TS -> EDIT_S -> EDIT_T on set_i; EDIT_T plus set_i -> IDLE.
  - change_i -> inc_o pulse. Digit wrap 9->0 is done by the counter, not by this block.
  - start_i and lap_i are ignored.
- LAP_VIEW:
  - change_i advances the read index, wrapping from lap_cnt_o-1 to 0.
  - start_i -> IDLE; the buffer is kept.
  - lap_i -> IDLE, flushing the buffer: lap_cnt_o = 0, entries unchanged but invalid.
  - set_i is ignored.
- disp_o equals the stored entry at the read index in LAP_VIEW, and time_i in all other states.
- run_o is 1 only in RUN.
- edit_sel_o in EDIT_H/TS/S/T is 0001/0010/0100/1000.

## Timing
- Reset values: state IDLE, run_o 0, clear_o 0, inc_o 0, edit_sel_o 0, lap_cnt_o 0, lap_view_o 0, read index 0, all buffer entries 0.
- disp_o at reset equals time_i.
- A pulse in cycle N takes effect on state and all registered outputs at edge N+1.
- clear_o and inc_o are high for exactly cycle N+1, and only in that cycle.
- A lap capture stores time_i as sampled at the edge ending cycle N.
- disp_o is combinational from state, read index, buffer and time_i; there is no added latency.
- Back-to-back pulses on consecutive cycles are each honoured.
- Reset mid-operation: returns immediately to the reset values, including flushing the buffer.
- Pulse inputs are never held longer than one cycle by the debouncers; a held input is not re-triggered internally.

## Structure
- Shared package/header stopwatch_ctrl_pkg contains:
  - state encodings (3-bit localparams IDLE_S = 0 … LAP_VIEW_S = 6);
  - BCD_W = 16;
  - one-hot digit select constants.
- Sub-module stopwatch_lap_buffer holds the LAP_DEPTH x 16 register file.
  - Write port: write enable plus append pointer.
  - Read port: combinational, read index in.
  - Provides count/full flags and a flush input.
- The FSM, read index and output registers live in stopwatch_ctrl.

## Test plan
- Reset, then start_i; after 10 cycles start_i -> run_o rises one cycle after the first pulse, falls one cycle after the second; clear_o stays 0.
- In RUN with time_i = 16'h1234 then 16'h2345, lap_i on each -> lap_cnt_o = 2. Stop, lap_i -> lap_view_o = 1, disp_o = 16'h1234. change_i -> 16'h2345; change_i -> 16'h1234 (wrap).
- Five lap_i in RUN with LAP_DEPTH = 4 -> lap_cnt_o saturates at 4; the fifth time value is absent from the view.
- In IDLE, set_i then change_i x3 -> edit_sel_o = 0001 and three single-cycle inc_o pulses. set_i x4 -> edit_sel_o steps 0010, 0100, 1000, then IDLE with edit_sel_o = 0.
- start_i and set_i in the same cycle in IDLE -> RUN entered, edit_sel_o stays 0. lap_i with an empty buffer in IDLE -> exactly one clear_o cycle.
- rstn_i asserted low while in LAP_VIEW with 3 laps stored -> immediately state IDLE, lap_cnt_o = 0, lap_view_o = 0, disp_o = time_i.
